pe_stream_server: RTL
=====================

# pe_stream_server

Responder side of the PE stream-request handshake. It accepts a stream request from the PE controller and reads compressed activation or compressed filter words from the on-chip buffer, channel by channel. It delivers those words to the PE over a valid/ready stream and returns the matching finish pulse (`Stream_input_finish_PE` or `Stream_filter_finish`) that the PE controller waits on.

## Interface
- `DATA_W`, 16: width of one compressed word (value+index).
- `MAX_CH`, 8: number of channels; equals `max_num_channel`.
- `MAX_LEN`, 256: words per channel region; `LEN_W = $clog2(MAX_LEN)+1`.
- `FILTER_BASE`, `MAX_CH*MAX_LEN`: buffer word address of the filter region.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  stream request present.
- `req_ready`  out  1  high only in IDLE.
- `req_is_filter`  in  1  0: activation stream, 1: filter stream.
- `req_ch_mask`  in  MAX_CH  channels to stream, served in ascending order.
- `num_of_compressed_data`  in  MAX_CH×LEN_W  activation words per channel, sampled at accept.
- `num_of_compressed_weight`  in  LEN_W  filter words per channel, sampled at accept.
- `mem_rd_en`  out  1  buffer read strobe.
- `mem_rd_addr`  out  $clog2(FILTER_BASE*2)  word address.
- `mem_rd_data`  in  DATA_W  valid the cycle after `mem_rd_en`.
- `stream_valid` / `stream_ready`  out / in  1  word handshake.
- `stream_data`  out  DATA_W  word.
- `stream_ch`  out  $clog2(MAX_CH)  source channel of the word.
- `stream_last`  out  1  final word of the request.
- `Stream_input_finish_PE`  out  1  one-cycle pulse, activation request done.
- `Stream_filter_finish`  out  1  one-cycle pulse, filter request done.
- `stall_cycles`  out  32  backpressure counter (see Configuration).

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `req_ready`=1. On `req_valid`:
  - latch type, mask and lengths;
  - select the lowest set channel with nonzero length;
  - go to READ, or to DONE if no channel qualifies.
- READ: issue one read per cycle while (FIFO occupancy + reads in flight) < 3. FIFO depth is fixed at 3.
  - Address: `ch*MAX_LEN + idx` for activations; `FILTER_BASE + ch*MAX_LEN + idx` for filters.
  - After the last index of a channel, advance to the next qualifying channel with no idle cycle.
  - Zero-length channels are skipped.
  - After the final read, go to DRAIN.
- DRAIN: pop the FIFO on each `stream_valid && stream_ready`. After the `stream_last` handshake, go to DONE.
- DONE: pulse the finish output for the latched type for one cycle, then return to IDLE.
- Each FIFO entry carries data, channel and the last flag.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset values: `req_ready`=1; every other output 0; FIFO empty; state IDLE.
- Request accepted at edge T:
  - `mem_rd_en` for word 0 asserted in cycle T+1;
  - data captured at the end of T+2;
  - `stream_valid` high in T+3.
- With `stream_ready` held high, throughput is one word per cycle, including across channel boundaries.
- Finish pulse is asserted in the cycle after the `stream_last` handshake. `req_ready` returns the cycle after that.
- Empty request (mask 0, or all selected lengths 0): finish pulse in T+1, no reads, no stream words.
- With `stream_ready` low, `stream_valid` and the stream payload hold stable. No reads are issued beyond the FIFO credit.
- `rst_n` low mid-request:
  - FIFO is flushed and in-flight data is discarded;
  - no finish pulse is generated;
  - block is in IDLE with `req_ready`=1 at the first edge after release.

## Configuration
- `PE_STREAM_STALL_CNT_EN`:
  - Defined: `stall_cycles` increments once per cycle with `stream_valid && !stream_ready`. It clears at each request accept and saturates at 2^32-1.
  - Undefined: `stall_cycles` is tied to 0 and the counter logic is absent.

## Test plan
- Activation stream, mask 3'b111, lengths 16/20/24, ready always high:
  - 60 words in order ch0, ch1, ch2;
  - addresses 0..15, 256..275, 512..535;
  - `stream_last` on word 60;
  - one `Stream_input_finish_PE` pulse; no gaps after T+3.
- Filter stream, mask 3'b111, `num_of_compressed_weight`=4:
  - 12 words at FILTER_BASE+{0..3, 256..259, 512..515};
  - one `Stream_filter_finish` pulse, no input-finish pulse.
- Mask 3'b101 with ch0 length 0 and ch2 length 8: only ch2 streamed (8 words). Mask 0: finish pulse at T+1, zero reads.
- Random `stream_ready` (50%) on the 60-word case:
  - every word delivered exactly once, payload stable while stalled;
  - reads in flight + occupancy never exceed 3;
  - with the macro defined, `stall_cycles` equals the counted stall cycles.
- `rst_n` asserted after 10 words: outputs return to reset values, no finish pulse. A new request afterwards streams from word 0.
- `req_valid` held high through DONE: a second request is accepted only when `req_ready` is high, i.e. the cycle after the finish pulse.

Source files
------------

// File: rtl/pe_stream_server_if.sv
// Word stream from pe_stream_server to the PE: valid/ready handshake with data,
// source channel and end-of-request flag.
interface pe_stream_server_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 3
);
  logic              stream_valid;
  logic              stream_ready;
  logic [DATA_W-1:0] stream_data;
  logic [CH_W-1:0]   stream_ch;
  logic              stream_last;

  modport master (output stream_valid, stream_data, stream_ch, stream_last,
                  input  stream_ready);
  modport slave  (input  stream_valid, stream_data, stream_ch, stream_last,
                  output stream_ready);
endinterface

// File: rtl/pe_stream_server.sv
// Serves PE stream requests: reads activation/filter words channel by channel into
// a 3-deep FIFO and streams them out. Optional macro: PE_STREAM_STALL_CNT_EN.
module pe_stream_server #(
  parameter int DATA_W      = 16,
  parameter int MAX_CH      = 8,
  parameter int MAX_LEN     = 256,
  parameter int LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int FILTER_BASE = MAX_CH * MAX_LEN,
  parameter int ADDR_W      = $clog2(FILTER_BASE * 2),
  parameter int CH_W        = $clog2(MAX_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_filter,
  input  logic [MAX_CH-1:0]       req_ch_mask,
  input  logic [MAX_CH*LEN_W-1:0] num_of_compressed_data,
  input  logic [LEN_W-1:0]        num_of_compressed_weight,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  pe_stream_server_if.master      stream,
  output logic                    Stream_input_finish_PE,
  output logic                    Stream_filter_finish,
  output logic [31:0]             stall_cycles
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic              is_filter_q;
  logic [MAX_CH-1:0] qual_q, qual_in;
  logic [LEN_W-1:0]  len_q  [MAX_CH];
  logic [LEN_W-1:0]  len_in [MAX_CH];
  logic [CH_W-1:0]   cur_ch_q, first_ch, next_ch;
  logic [LEN_W-1:0]  idx_q;
  logic              first_found, next_found;

  logic              pend_q, pend_last_q;
  logic [CH_W-1:0]   pend_ch_q;

  logic [DATA_W-1:0] fifo_data [3];
  logic [CH_W-1:0]   fifo_ch   [3];
  logic              fifo_last [3];
  logic [1:0]        rd_ptr_q, wr_ptr_q, count_q;

  logic accept, issue, chan_end, final_read, fifo_valid, push, pop;

  // Per-channel qualification of an incoming request: selected and nonzero length.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    qual_in     = '0;
    for (int unsigned c = 0; c < MAX_CH; c++) begin
      len_in[c]  = req_is_filter ? num_of_compressed_weight
                                 : num_of_compressed_data[c*LEN_W +: LEN_W];
      qual_in[c] = req_ch_mask[c] && (len_in[c] != '0);
      if (qual_in[c] && !first_found) begin
        first_found = 1'b1;
        first_ch    = CH_W'(c);
      end
    end
  end

  always_comb begin
    next_found = 1'b0;
    next_ch    = cur_ch_q;
    for (int unsigned c = 0; c < MAX_CH; c++) begin
      if (qual_q[c] && (CH_W'(c) > cur_ch_q) && !next_found) begin
        next_found = 1'b1;
        next_ch    = CH_W'(c);
      end
    end
  end

  // Credit counts reads whose data has not yet landed, so the FIFO never overflows.
  always_comb begin
    state_d    = state_q;
    accept     = (state_q == IDLE) && req_valid;
    issue      = (state_q == READ) && ((3'(count_q) + 3'(pend_q)) < 3'd3);
    chan_end   = (idx_q == len_q[cur_ch_q] - LEN_W'(1));
    final_read = issue && chan_end && !next_found;
    fifo_valid = (count_q != 2'd0);
    pop        = fifo_valid && stream.stream_ready;
    push       = pend_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = first_found ? READ : DONE;
      READ:  if (final_read) state_d = DRAIN;
      DRAIN: if (pop && fifo_last[rd_ptr_q]) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_filter_q <= 1'b0;
      qual_q      <= '0;
      cur_ch_q    <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_ch_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned c = 0; c < MAX_CH; c++) len_q[c] <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        fifo_data[i] <= '0;
        fifo_ch[i]   <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        is_filter_q <= req_is_filter;
        qual_q      <= qual_in;
        cur_ch_q    <= first_ch;
        idx_q       <= '0;
        for (int unsigned c = 0; c < MAX_CH; c++) len_q[c] <= len_in[c];
      end else if (issue) begin
        if (chan_end) begin
          cur_ch_q <= next_ch;
          idx_q    <= '0;
        end else begin
          idx_q <= idx_q + LEN_W'(1);
        end
      end
      pend_q      <= issue;
      pend_ch_q   <= cur_ch_q;
      pend_last_q <= final_read;
      if (push) begin
        fifo_data[wr_ptr_q] <= mem_rd_data;
        fifo_ch[wr_ptr_q]   <= pend_ch_q;
        fifo_last[wr_ptr_q] <= pend_last_q;
        wr_ptr_q            <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    mem_rd_addr = '0;
    if (issue)
      mem_rd_addr = (is_filter_q ? ADDR_W'(FILTER_BASE) : ADDR_W'(0))
                  + ADDR_W'(cur_ch_q) * ADDR_W'(MAX_LEN) + ADDR_W'(idx_q);
  end

  assign req_ready              = (state_q == IDLE);
  assign mem_rd_en              = issue;
  assign stream.stream_valid    = fifo_valid;
  assign stream.stream_data     = fifo_valid ? fifo_data[rd_ptr_q] : '0;
  assign stream.stream_ch       = fifo_valid ? fifo_ch[rd_ptr_q] : '0;
  assign stream.stream_last     = fifo_valid && fifo_last[rd_ptr_q];
  assign Stream_input_finish_PE = (state_q == DONE) && !is_filter_q;
  assign Stream_filter_finish   = (state_q == DONE) && is_filter_q;

`ifdef PE_STREAM_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              stall_q <= '0;
    else if (accept)                                         stall_q <= '0;
    else if (fifo_valid && !stream.stream_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
